// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity sense and default baud constants.
// UART_RX_PARITY_EN adds the PARITY state to the state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned CLK_HZ               = 7_372_800;
  localparam int unsigned BAUD_DEFAULT         = 115_200;
  localparam int unsigned OVERSAMPLE_DEFAULT   = 16;
  localparam int unsigned CLK_PER_TICK_DEFAULT = CLK_HZ / (BAUD_DEFAULT * OVERSAMPLE_DEFAULT);

  // Received parity is bad when data XOR parity bit disagrees with the configured sense.
  function automatic logic parity_bad(input logic sense, input logic data_xor, input logic sample);
    return (data_xor ^ sample) != sense;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every CLK_PER_TICK cycles, realigned by restart.
// No configuration macros.
module uart_baud_tick #(
  parameter int CLK_PER_TICK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= TC_LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a one-deep holding register and ready/valid output.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int CLK_PER_TICK = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LOAD = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(OVERSAMPLE - 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t state, state_nxt;

  logic                 rx_s1, rx_s2, rx_prev;
  logic                 tick, restart, sample, fall;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 ferr_acc;
  logic                 done;
  logic [DATA_BITS-1:0] done_word;
  logic                 done_ferr;
  logic                 done_perr;

  uart_baud_tick #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall   = rx_prev & ~rx_s2;
  assign sample = tick && (tick_cnt == '0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    unique case (state)
      IDLE: if (fall) begin
        state_nxt = START;
        restart   = 1'b1;
      end
      START: if (sample) state_nxt = rx_s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (sample && bit_cnt == LAST_DATA) state_nxt = PARITY;
      PARITY: if (sample) state_nxt = STOP;
`else
      DATA:   if (sample && bit_cnt == LAST_DATA) state_nxt = STOP;
`endif
      STOP:  if (sample && bit_cnt == LAST_STOP) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic perr_acc;
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  always_ff @(posedge clk) begin
    if (!rst) perr_acc <= 1'b0;
    else if (state == START && sample) perr_acc <= 1'b0;
    else if (state == PARITY && sample) perr_acc <= parity_bad(PAR_SENSE, ^shift_reg, rx_s2);
  end
`else
  logic perr_acc;
  logic unused_parity_cfg;
  assign perr_acc          = 1'b0;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // Sampling datapath; the done strobe delays the holding-register load by one clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ferr_acc  <= 1'b0;
      done      <= 1'b0;
      done_word <= '0;
      done_ferr <= 1'b0;
      done_perr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (fall) begin
          tick_cnt <= HALF_LOAD;
          bit_cnt  <= '0;
        end
      end else if (tick) begin
        tick_cnt <= (tick_cnt == '0) ? FULL_LOAD : tick_cnt - 1'b1;
      end
      if (sample) begin
        unique case (state)
          START: begin
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
          end
          DATA: begin
            shift_reg <= {rx_s2, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
          end
          STOP: begin
            if (bit_cnt == LAST_STOP) begin
              done      <= 1'b1;
              done_word <= shift_reg;
              done_ferr <= ferr_acc | ~rx_s2;
              done_perr <= perr_acc;
              bit_cnt   <= '0;
            end else begin
              ferr_acc <= ferr_acc | ~rx_s2;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: a load while full and not being accepted drops the word and flags overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (dout_valid && !dout_ready) begin
        overrun <= 1'b1;
      end else begin
        dout       <= done_word;
        dout_valid <= 1'b1;
        frame_err  <= done_ferr;
        parity_err <= done_perr;
        overrun    <= 1'b0;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at default parameters; UART_RX_PARITY_EN adds parity frames.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 16 * 4;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   base;
  exp_t exp_q[$];
  exp_t e;

  uart_rx_param dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (dout_valid) valid_cnt++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h expected none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("mon_dout", 32'(dout), 32'(e.data));
          chk("mon_frame_err", 32'(frame_err), 32'(e.ferr));
          chk("mon_parity_err", 32'(parity_err), 32'(e.perr));
          chk("mon_overrun", 32'(overrun), 32'(e.ovr));
        end
      end
    end
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_clk();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) wait_clk();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_val);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit);
    drive_bit(1'b1);
  endtask
`endif

  task automatic pulse_ready();
    dout_ready = 1'b1;
    wait_clk();
    dout_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    dout_ready = 1'b0;
    repeat (5) wait_clk();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    idle(10);

    // clean frame, consumer always ready
    dout_ready = 1'b1;
    base = valid_cnt;
    exp_q.push_back('{data: 8'hA5, ferr: 1'b0, perr: 1'b0, ovr: 1'b0});
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_valid_cycles", 32'(valid_cnt - base), 32'd1);
    chk("a5_busy_after", 32'(busy), 32'h0);

    // 3-tick low glitch must be rejected at the half-bit sample
    base = valid_cnt;
    rx = 1'b0;
    repeat (12) wait_clk();
    rx = 1'b1;
    repeat (8) wait_clk();
    chk("glitch_busy_mid", 32'(busy), 32'h1);
    repeat (25) wait_clk();
    chk("glitch_busy_end", 32'(busy), 32'h0);
    idle(100);
    chk("glitch_no_valid", 32'(valid_cnt - base), 32'd0);

    // framing error held until accepted
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("ferr_dout", 32'(dout), 32'h3C);
    chk("ferr_valid", 32'(dout_valid), 32'h1);
    chk("ferr_flag", 32'(frame_err), 32'h1);
    idle(50);
    chk("ferr_hold", 32'(frame_err), 32'h1);
    exp_q.push_back('{data: 8'h3C, ferr: 1'b1, perr: 1'b0, ovr: 1'b0});
    pulse_ready();
    chk("ferr_valid_clr", 32'(dout_valid), 32'h0);
    chk("ferr_flag_clr", 32'(frame_err), 32'h0);
    idle(20);

    // overrun: second back-to-back word dropped
    exp_q.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0, ovr: 1'b1});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    chk("ovr_dout", 32'(dout), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    pulse_ready();
    chk("ovr_valid_clr", 32'(dout_valid), 32'h0);
    chk("ovr_flag_clr", 32'(overrun), 32'h0);
    idle(20);

`ifdef UART_RX_PARITY_EN
    dout_ready = 1'b1;
    exp_q.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1, ovr: 1'b0});
    send_frame_par(8'h07, 1'b0);
    idle(20);
    exp_q.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b0, ovr: 1'b0});
    send_frame_par(8'h07, 1'b1);
    idle(20);
`endif

    // reset in the middle of data bit 4 of 0xFF
    dout_ready = 1'b1;
    base = valid_cnt;
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) wait_clk();
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    repeat (3) wait_clk();
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(dout_valid), 32'h0);
    rst = 1'b1;
    idle(200);
    chk("midrst_no_output", 32'(valid_cnt - base), 32'd0);
    exp_q.push_back('{data: 8'h5A, ferr: 1'b0, perr: 1'b0, ovr: 1'b0});
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("after_rst_count", 32'(valid_cnt - base), 32'd1);

    idle(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, oversample ticks per bit (even, 8..32).
REQ-003 SHALL have parameter CLK_PER_TICK, default 4, clk cycles per oversample tick (7.3728 MHz / 16 / 4 = 115200 baud).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have parameter PARITY_ODD, default 0, parity sense when parity compiled in (0 even, 1 odd).
REQ-006 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have ports: rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have ports: rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have ports: dout  output  DATA_BITS  received word, LSB first on line.
REQ-010 SHALL have ports: dout_valid  output  1  holding register full.
REQ-011 SHALL have ports: dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-012 SHALL have ports: frame_err, parity_err, overrun  output  1 each  status flags for the held word.
REQ-013 SHALL have ports: busy  output  1  high whenever FSM not IDLE.

Function
REQ-014 rx SHALL pass through a two-flop synchroniser; all decisions use the synchronised value.
REQ-015 Tick generator SHALL pulse one clk every CLK_PER_TICK cycles, free-running, restarted on start-edge detection.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START on synchronised high-to-low transition; tick-count cleared.
REQ-018 START: at OVERSAMPLE/2 ticks sample rx; low -> DATA; high -> IDLE (glitch rejected, no flags, no output).
REQ-019 DATA: sample every OVERSAMPLE ticks thereafter, shift in LSB first; after DATA_BITS samples -> PARITY (if compiled) else STOP.
REQ-020 PARITY: one sample; parity_err set if XOR(data, sample) != PARITY_ODD.
REQ-021 STOP: STOP_BITS samples; any low sample sets frame_err; after last sample -> IDLE.
REQ-022 Word and flags SHALL load into holding register on the clk after the final stop sample; dout_valid rises same edge.
REQ-023 Handshake: dout_valid and dout_ready both high at edge -> dout_valid, frame_err, parity_err, overrun clear next cycle unless a new word loads same edge.
REQ-024 Simultaneous load and accept SHALL load new word, dout_valid stays high, overrun not set.
REQ-025 Load while dout_valid high and not accepted SHALL drop the new word, keep old dout, set overrun (sticky until accept).
REQ-026 Framing-error words SHALL still be delivered with frame_err high.
REQ-027 Receiver SHALL accept a new start edge in IDLE on the cycle after STOP completes (back-to-back frames).

Reset
REQ-028 rst low at a clk edge SHALL force IDLE, dout=0, dout_valid=0, all flags 0, busy=0, synchroniser flops=1, counters=0.
REQ-029 Reset mid-frame SHALL discard the partial word; no output after release until a fresh start edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state present, one parity bit expected after data.
REQ-031 Macro absent: PARITY state and parity logic removed, DATA->STOP directly, parity_err tied 0, PARITY_ODD ignored.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state typedef, parity-sense constants and default baud constants shared with the transmitter.
REQ-033 Sub-module uart_baud_tick SHALL implement the tick generator (ports clk, rst, restart, tick).

Verification
REQ-034 Defaults, send 0xA5 8N1 at 115200, dout_ready=1 -> dout=0xA5, dout_valid one cycle, all flags 0.
REQ-035 Low glitch of 3 ticks on rx -> back to IDLE, dout_valid never asserts, busy drops after OVERSAMPLE/2 ticks.
REQ-036 Send 0x3C with stop bit low, dout_ready=0 -> dout=0x3C, dout_valid=1, frame_err=1 held until dout_ready pulse.
REQ-037 dout_ready=0, send 0x11 then 0x22 back-to-back -> dout=0x11, overrun=1; after accept, flags clear, dout_valid=0.
REQ-038 UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-039 Assert rst low during DATA bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered, flags 0.
